// File: rtl/data_cache.sv
// Direct-mapped, write-back / write-allocate data cache for the MEM stage.
// Misses freeze the pipeline while whole lines move one word per beat.
module data_cache #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addrM,
  input  logic [31:0] writeDataM,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  addressingModeM,
  output logic [31:0] readDataM,
  output logic        cacheStallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                 r_state, w_next;
  logic [NUM_LINES-1:0]   r_valid, r_dirty;
  logic [TAG_W-1:0]       r_tag  [NUM_LINES];
  logic [31:0]            r_data [NUM_LINES*LINE_WORDS];
  logic [OFF_W-1:0]       r_beat;
  logic [TAG_W-1:0]       r_req_tag;

  logic [OFF_W-1:0] w_woff;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_req, w_load, w_store, w_hit, w_miss, w_last;
  logic [31:0]      w_word, w_load_data, w_wd;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [3:0]       w_be;

  assign w_woff  = addrM[2 +: OFF_W];
  assign w_idx   = addrM[2+OFF_W +: IDX_W];
  assign w_tag   = addrM[31 -: TAG_W];
  assign w_req   = memReadM | memWriteM;
  assign w_store = memWriteM;
  assign w_load  = memReadM & ~memWriteM;
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss  = (r_state == IDLE) && w_req && !w_hit;
  assign w_last  = (r_beat == OFF_W'(LINE_WORDS-1));
  assign w_word  = r_data[{w_idx, w_woff}];
  assign w_byte  = w_word[{addrM[1:0], 3'b000} +: 8];
  assign w_half  = addrM[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (addressingModeM)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = w_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (addressingModeM[1:0])
      2'b00: begin
        w_be = 4'b0001 << addrM[1:0];
        w_wd = {4{writeDataM[7:0]}};
      end
      2'b01: begin
        w_be = addrM[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{writeDataM[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = writeDataM;
      end
    endcase
  end

  always_comb begin
    w_next      = r_state;
    cacheStallM = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    readDataM   = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          cacheStallM = 1'b1;
          w_next      = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL;
        end else if (w_load) begin
          readDataM = w_load_data;
        end
      end
      WRITEBACK: begin
        cacheStallM = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {r_tag[w_idx], w_idx, r_beat, 2'b00};
        mem_wdata   = r_data[{w_idx, r_beat}];
        if (mem_ack && w_last) w_next = REFILL;
      end
      REFILL: begin
        cacheStallM = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = {r_req_tag, w_idx, r_beat, 2'b00};
        if (mem_ack && w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_req_tag <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_req_tag <= w_tag;
      if (r_state != IDLE && mem_ack) r_beat <= w_last ? '0 : r_beat + OFF_W'(1);
      if (r_state == REFILL && mem_ack && w_last) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (r_state == IDLE && w_store && w_hit) r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tags and data need no reset; a cleared valid bit hides whatever they hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == REFILL && mem_ack) begin
        r_data[{w_idx, r_beat}] <= mem_rdata;
        if (w_last) r_tag[w_idx] <= r_req_tag;
      end else if (r_state == IDLE && w_store && w_hit) begin
        for (int l = 0; l < 4; l++)
          if (w_be[l]) r_data[{w_idx, w_woff}][8*l +: 8] <= w_wd[8*l +: 8];
      end
    end
  end
endmodule
